// File: rtl/banked_main_mem.sv
// banked_main_mem: four-bank, word-organised main memory behind the cache controller.
// One read or write is accepted per cycle. Banks interleave on addr[2:1].
// After an accept, a bank stays occupied for BANK_BUSY cycles.
// Read data returns a fixed RD_LAT cycles after accept, followed by an output register.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   addr      byte address; addr[0] must be 0; bank = addr[2:1]
//   data_in   write data
//   rd, wr    level request strobes, sampled every cycle
//   data_out  read data, valid while rd_valid is high
//   rd_valid  one-cycle pulse per returned read, in accept order
//   stall     combinational: a request is present and its bank is busy
//   busy      per-bank occupancy flags
//   err       registered one-cycle pulse for an illegal request
module banked_main_mem #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BANK_BUSY = 4,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int unsigned NumBanks = 4;
  localparam int unsigned Words    = 2 ** (ADDR_W - 1);
  localparam int unsigned CntW     = $clog2(BANK_BUSY + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(BANK_BUSY - 1);

  logic [DATA_W-1:0] mem [Words];

  logic [CntW-1:0]   cnt_q [NumBanks];
  logic [CntW-1:0]   cnt_d [NumBanks];
  logic [DATA_W-1:0] pd_q  [RD_LAT];
  logic [RD_LAT-1:0] pv_q;

  logic [1:0]        bank;
  logic [ADDR_W-2:0] idx;
  logic              req;
  logic              legal;
  logic              accept;

  assign bank   = addr[2:1];
  assign idx    = addr[ADDR_W-1:1];
  assign req    = rd | wr;
  assign legal  = (rd ^ wr) && !addr[0];
  assign accept = legal && !busy[bank];
  assign stall  = req && busy[bank];

  always_comb begin
    busy = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      busy[b]  = (cnt_q[b] != '0);
      // Saturating countdown; a fresh accept reloads the counter.
      cnt_d[b] = (cnt_q[b] != '0) ? cnt_q[b] - CntW'(1) : '0;
      if (accept && (bank == 2'(b))) begin
        cnt_d[b] = CntLoad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        cnt_q[b] <= '0;
      end
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pd_q[i] <= '0;
      end
      pv_q     <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      // Data is snapshotted at accept, so later writes cannot disturb an in-flight read.
      pv_q[0] <= accept && rd;
      if (accept && rd) begin
        pd_q[0] <= mem[idx];
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      rd_valid <= pv_q[RD_LAT-1];
      if (pv_q[RD_LAT-1]) begin
        data_out <= pd_q[RD_LAT-1];
      end
      err <= req && !legal;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_banked_main_mem.sv
module tb_banked_main_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_main_mem #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .BANK_BUSY(4),
    .RD_LAT   (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .rd      (rd),
    .wr      (wr),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .stall   (stall),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [bit [14:0]];
  int unsigned cyc     = 0;
  int unsigned n_vec   = 0;
  int unsigned n_err   = 0;
  logic        err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every returned read must match the oldest outstanding expectation, on the expected cycle.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_rd_valid", {31'b0, rd_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rd_data", data_out, e.data);
        check_eq("rd_cycle", cyc, e.due);
      end
    end
  end

  // One cycle with a request held; expected stall comes from the test plan, not the DUT.
  task automatic req_cycle(input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic exp_stall, input string tag);
    logic illegal;
    rd = r; wr = w; addr = a; data_in = d;
    illegal = (r || w) && (!(r ^ w) || a[0]);
    @(negedge clk);
    check_eq({tag, "_stall"}, stall, exp_stall);
    check_eq({tag, "_err"}, err, err_exp);
    if (!exp_stall && !illegal && (r ^ w)) begin
      if (w) model[a[15:1]] = d;
      else   sb.push_back('{data: model[a[15:1]], due: cyc + 3});
    end
    err_exp = illegal;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_busy(input logic [3:0] exp_busy, input string tag);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check_eq({tag, "_busy"}, busy, exp_busy);
    check_eq({tag, "_err"}, err, err_exp);
    check_eq({tag, "_stall"}, stall, 1'b0);
    err_exp = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held with a read pending.
    rst = 1'b0; rd = 1'b1; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_busy", busy, 4'b0000);
    check_eq("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Preload; bank 0 is rewritten exactly BANK_BUSY cycles after its first write.
    req_cycle(1'b0, 1'b1, 16'h0008, 16'h5555, 1'b0, "w08");
    req_cycle(1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, "w02");
    req_cycle(1'b0, 1'b1, 16'h0004, 16'h3333, 1'b0, "w04");
    req_cycle(1'b0, 1'b1, 16'h0006, 16'h4444, 1'b0, "w06");
    req_cycle(1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, "w00");
    idle(3);

    // Four banks read back-to-back.
    req_cycle(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, "r00");
    req_cycle(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, "r02");
    req_cycle(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, "r04");
    req_cycle(1'b1, 1'b0, 16'h0006, 16'h0, 1'b0, "r06");
    // Bank 0 (accepted three edges ago) has just counted out; banks 1..3 are still occupied.
    idle_busy(4'b1110, "after4");

    // Write then read-after-write to the same bank.
    req_cycle(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "w10");
    for (int i = 0; i < 3; i++) req_cycle(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, "r10_early");
    req_cycle(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, "r10");

    // Same-bank conflict between consecutive reads.
    idle(3);
    req_cycle(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, "rb0_a");
    for (int i = 0; i < 3; i++) req_cycle(1'b1, 1'b0, 16'h0008, 16'h0, 1'b1, "rb0_held");
    req_cycle(1'b1, 1'b0, 16'h0008, 16'h0, 1'b0, "rb0_b");

    // Illegal requests.
    idle(4);
    req_cycle(1'b1, 1'b1, 16'h0002, 16'h0, 1'b0, "ill_rw");
    req_cycle(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, "ill_odd");
    idle_busy(4'b0000, "ill_1");
    idle_busy(4'b0000, "ill_2");

    // Reset while a read is in flight; the dropped read must never return.
    rd = 1'b1; wr = 1'b0; addr = 16'h0004;
    @(negedge clk);
    check_eq("inflight_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rd = 1'b0;
    rst = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", busy, 4'b0000);
    check_eq("midrst_rd_valid", rd_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_busy(4'b0000, "post_rst");
    req_cycle(1'b1, 1'b0, 16'h0006, 16'h0, 1'b0, "post_rst_r06");

    idle(6);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
